// File: rtl/m_proc12.sv
// m_proc12 -- five-stage pipelined MIPS-subset core (IF/ID/EX/MEM/WB).
//
// Instruction and data RAMs are external, synchronous, 1-cycle read latency.
// The fetched word arrives on w_imem_data in the cycle after its address,
// so that cycle is the instruction's ID stage; IfId only tracks pc + valid.
//
// Ports:
//   w_clk          clock, all state on rising edge
//   w_rst          asynchronous active-low reset
//   w_imem_addr    instruction word address
//   w_imem_data    instruction word (valid 1 cycle after address)
//   w_dmem_addr    data word address (ALU result [DMEM_AW+1:2])
//   w_dmem_we      store enable, asserted in the store's MEM cycle
//   w_dmem_wdata   store data
//   w_dmem_rdata   load data (valid 1 cycle after address, used in WB)
//   r_rout         last value written to register ROUT_REG
//   r_halt         sticky halt flag (HALT reached WB)
//   r_cycles       cycles since reset, frozen at halt
//   r_stalls       ID stall cycles since reset, frozen at halt
module m_proc12 #(
    parameter int IMEM_AW  = 12,
    parameter int DMEM_AW  = 12,
    parameter bit FWD_EN   = 1'b1,
    parameter int ROUT_REG = 30
) (
    input  logic               w_clk,
    input  logic               w_rst,
    output logic [IMEM_AW-1:0] w_imem_addr,
    input  logic [31:0]        w_imem_data,
    output logic [DMEM_AW-1:0] w_dmem_addr,
    output logic               w_dmem_we,
    output logic [31:0]        w_dmem_wdata,
    input  logic [31:0]        w_dmem_rdata,
    output logic [31:0]        r_rout,
    output logic               r_halt,
    output logic [31:0]        r_cycles,
    output logic [31:0]        r_stalls
);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    // we is never set for rd==0, so a destination match implies a real register
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic        ld;
        logic        st;
        logic        hlt;
        alu_op_e     op;
        logic        use_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic        ld;
        logic        st;
        logic        hlt;
        logic [31:0] alu;
        logic [31:0] sdata;
    } exme_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic        ld;
        logic        hlt;
        logic [31:0] alu;
    } mewb_t;

    logic [31:0] r_pc, ifid_pc;
    logic        ifid_vld;
    idex_t       idex, id_next;
    exme_t       exme, ex_next;
    mewb_t       mewb;
    logic [31:0] rf [32];

    // ---------------- WB ----------------
    logic        wb_we;
    logic [31:0] wb_data;
    assign wb_data = mewb.ld ? w_dmem_rdata : mewb.alu;
    assign wb_we   = mewb.we && !r_halt;

    always_ff @(posedge w_clk) begin
        if (wb_we) rf[mewb.rd] <= wb_data;
    end

    // ---------------- ID ----------------
    logic [5:0]  op, funct;
    logic [4:0]  rs_f, rt_f, rd_f;
    logic [31:0] simm;
    logic        unused_shamt;
    assign op    = w_imem_data[31:26];
    assign rs_f  = w_imem_data[25:21];
    assign rt_f  = w_imem_data[20:16];
    assign rd_f  = w_imem_data[15:11];
    assign funct = w_imem_data[5:0];
    assign simm  = {{16{w_imem_data[15]}}, w_imem_data[15:0]};
    assign unused_shamt = ^w_imem_data[10:6];

    logic        d_we, d_ld, d_st, d_hlt, d_imm, use_rs, use_rt, is_beq, is_bne, is_br;
    logic [4:0]  d_rd;
    alu_op_e     d_op;

    always_comb begin
        d_we = 1'b0; d_rd = rd_f; d_ld = 1'b0; d_st = 1'b0; d_hlt = 1'b0;
        d_op = ALU_ADD; d_imm = 1'b0; use_rs = 1'b0; use_rt = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0;
        if (ifid_vld) begin
            case (op)
                6'h00: begin
                    d_we = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
                    case (funct)
                        6'h20: d_op = ALU_ADD;
                        6'h22: d_op = ALU_SUB;
                        6'h24: d_op = ALU_AND;
                        6'h25: d_op = ALU_OR;
                        6'h2a: d_op = ALU_SLT;
                        default: begin d_we = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
                    endcase
                end
                6'h08: begin d_we = 1'b1; d_rd = rt_f; d_imm = 1'b1; use_rs = 1'b1; end
                6'h23: begin d_we = 1'b1; d_rd = rt_f; d_imm = 1'b1; use_rs = 1'b1; d_ld = 1'b1; end
                6'h2b: begin d_st = 1'b1; d_imm = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                6'h04: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                6'h05: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
                6'h11: d_hlt = 1'b1;
                default: ;
            endcase
        end
        if (d_rd == 5'd0) d_we = 1'b0;
    end
    assign is_br = is_beq || is_bne;

    // Register read with write-through from WB
    logic [31:0] rs_val, rt_val;
    assign rs_val = (rs_f == 5'd0) ? 32'd0 : (wb_we && mewb.rd == rs_f) ? wb_data : rf[rs_f];
    assign rt_val = (rt_f == 5'd0) ? 32'd0 : (wb_we && mewb.rd == rt_f) ? wb_data : rf[rt_f];

    // Hazard detection; sources only count when the instruction really reads them
    logic ex_hit, me_hit, stall;
    assign ex_hit = idex.we && ((use_rs && idex.rd == rs_f) || (use_rt && idex.rd == rt_f));
    assign me_hit = exme.we && ((use_rs && exme.rd == rs_f) || (use_rt && exme.rd == rt_f));

    always_comb begin
        if (FWD_EN)
            stall = (ex_hit && idex.ld) || (is_br && ex_hit) || (is_br && me_hit && exme.ld);
        else
            stall = ex_hit || me_hit;
    end

    // Branch compare; ExMe ALU bypass only in forwarding mode, WB comes via write-through
    logic [31:0] br_a, br_b, br_tgt;
    logic        br_taken;
    assign br_a = (FWD_EN && exme.we && !exme.ld && exme.rd == rs_f) ? exme.alu : rs_val;
    assign br_b = (FWD_EN && exme.we && !exme.ld && exme.rd == rt_f) ? exme.alu : rt_val;
    assign br_tgt   = ifid_pc + 32'd4 + {simm[29:0], 2'b00};
    assign br_taken = (is_beq && br_a == br_b) || (is_bne && br_a != br_b);

    // A stalled ID re-reads its own word so the RAM output stays on it
    assign w_imem_addr = stall ? ifid_pc[IMEM_AW+1:2] : r_pc[IMEM_AW+1:2];

    always_comb begin
        id_next         = '0;
        id_next.we      = d_we;
        id_next.rd      = d_rd;
        id_next.ld      = d_ld;
        id_next.st      = d_st;
        id_next.hlt     = d_hlt;
        id_next.op      = d_op;
        id_next.use_imm = d_imm;
        id_next.rs      = rs_f;
        id_next.rt      = rt_f;
        id_next.a       = rs_val;
        id_next.b       = rt_val;
        id_next.imm     = simm;
    end

    // ---------------- EX ----------------
    logic [31:0] ex_a, ex_b, ex_opb, ex_res;
    always_comb begin
        ex_a = idex.a;
        ex_b = idex.b;
        if (FWD_EN) begin
            if (exme.we && !exme.ld && exme.rd == idex.rs) ex_a = exme.alu;
            else if (mewb.we && mewb.rd == idex.rs)        ex_a = wb_data;
            if (exme.we && !exme.ld && exme.rd == idex.rt) ex_b = exme.alu;
            else if (mewb.we && mewb.rd == idex.rt)        ex_b = wb_data;
        end
    end
    assign ex_opb = idex.use_imm ? idex.imm : ex_b;

    always_comb begin
        case (idex.op)
            ALU_SUB: ex_res = ex_a - ex_opb;
            ALU_AND: ex_res = ex_a & ex_opb;
            ALU_OR:  ex_res = ex_a | ex_opb;
            ALU_SLT: ex_res = {31'd0, $signed(ex_a) < $signed(ex_opb)};
            default: ex_res = ex_a + ex_opb;
        endcase
    end

    always_comb begin
        ex_next       = '0;
        ex_next.we    = idex.we;
        ex_next.rd    = idex.rd;
        ex_next.ld    = idex.ld;
        ex_next.st    = idex.st;
        ex_next.hlt   = idex.hlt;
        ex_next.alu   = ex_res;
        ex_next.sdata = ex_b;
    end

    // ---------------- MEM ----------------
    // A store directly behind a HALT sits in MEM while the HALT is in WB; kill it
    assign w_dmem_addr  = exme.alu[DMEM_AW+1:2];
    assign w_dmem_wdata = exme.sdata;
    assign w_dmem_we    = exme.st && !r_halt && !mewb.hlt;

    // ---------------- pipeline registers ----------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_pc     <= '0;
            ifid_pc  <= '0;
            ifid_vld <= 1'b0;
            idex     <= '0;
            exme     <= '0;
            mewb     <= '0;
        end else if (!r_halt) begin
            if (!stall) begin
                r_pc     <= br_taken ? br_tgt : r_pc + 32'd4;
                ifid_pc  <= r_pc;
                ifid_vld <= 1'b1;
            end
            idex     <= stall ? '0 : id_next;
            exme     <= ex_next;
            mewb.we  <= exme.we;
            mewb.rd  <= exme.rd;
            mewb.ld  <= exme.ld;
            mewb.hlt <= exme.hlt;
            mewb.alu <= exme.alu;
        end
    end

    // ---------------- status / counters ----------------
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_rout   <= '0;
            r_halt   <= 1'b0;
            r_cycles <= '0;
            r_stalls <= '0;
        end else if (!r_halt) begin
            r_cycles <= r_cycles + 32'd1;
            if (stall) r_stalls <= r_stalls + 32'd1;
            if (mewb.hlt) r_halt <= 1'b1;
            if (wb_we && mewb.rd == 5'(ROUT_REG)) r_rout <= wb_data;
        end
    end

endmodule

// File: tb/tb_m_proc12.sv
// tb_m_proc12 -- runs small programs on a forwarding core (dut1) and an
// interlock-only core (dut0) side by side, each with its own 1-cycle RAMs.
// Results are compared against a vector table; stores of dut1 against a queue.
module tb_m_proc12;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] imem [0:4095];
    logic [31:0] dmem0 [0:4095];
    logic [31:0] dmem1 [0:4095];

    logic [11:0] ia0, ia1, da0, da1;
    logic [31:0] id0, id1, wd0, wd1, rd0, rd1;
    logic        we0, we1, halt0, halt1;
    logic [31:0] rout0, rout1, cyc0, cyc1, stl0, stl1;

    always @(posedge clk) begin
        id0 <= imem[ia0];
        id1 <= imem[ia1];
        if (we0) dmem0[da0] <= wd0;
        if (we1) dmem1[da1] <= wd1;
        rd0 <= dmem0[da0];
        rd1 <= dmem1[da1];
    end

    m_proc12 #(.IMEM_AW(12), .DMEM_AW(12), .FWD_EN(1'b0), .ROUT_REG(30)) dut0 (
        .w_clk(clk), .w_rst(rst_n), .w_imem_addr(ia0), .w_imem_data(id0),
        .w_dmem_addr(da0), .w_dmem_we(we0), .w_dmem_wdata(wd0), .w_dmem_rdata(rd0),
        .r_rout(rout0), .r_halt(halt0), .r_cycles(cyc0), .r_stalls(stl0));

    m_proc12 #(.IMEM_AW(12), .DMEM_AW(12), .FWD_EN(1'b1), .ROUT_REG(30)) dut1 (
        .w_clk(clk), .w_rst(rst_n), .w_imem_addr(ia1), .w_imem_data(id1),
        .w_dmem_addr(da1), .w_dmem_we(we1), .w_dmem_wdata(wd1), .w_dmem_rdata(rd1),
        .r_rout(rout1), .r_halt(halt1), .r_cycles(cyc1), .r_stalls(stl1));

    // selected core under test
    logic        sel;
    logic        t_halt, t_we;
    logic [31:0] t_rout, t_cyc, t_stl;
    logic [11:0] t_ia;
    assign t_halt = sel ? halt1 : halt0;
    assign t_we   = sel ? we1   : we0;
    assign t_rout = sel ? rout1 : rout0;
    assign t_cyc  = sel ? cyc1  : cyc0;
    assign t_stl  = sel ? stl1  : stl0;
    assign t_ia   = sel ? ia1   : ia0;

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } st_t;
    st_t sb_q[$];
    st_t sb_e;

    typedef struct { int prog; bit fwd; logic [31:0] rout; logic [31:0] stalls; } vec_t;
    vec_t vecs [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] i_t(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] r_t(int fn, int rs, int rt, int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    localparam logic [31:0] HALT = {6'h11, 26'd0};

    task automatic load_prog(input int p);
        logic [31:0] pr[$];
        case (p)
            0: pr = {i_t(8,0,1,5), i_t(8,1,2,3), r_t('h20,1,2,30), HALT, i_t(8,0,30,77)};
            1: pr = {i_t(8,0,4,7), i_t('h2b,0,4,0), i_t('h23,0,3,0), r_t('h20,3,3,30), HALT,
                     i_t('h2b,0,4,4), i_t(8,0,30,77)};
            2: pr = {i_t(8,0,8,1), i_t(5,8,0,2), i_t(8,0,30,9), i_t(8,0,30,99),
                     r_t('h20,30,30,30), HALT, i_t(8,0,30,77)};
            default: pr = {i_t(8,0,0,44), i_t(8,0,1,-3), i_t(8,0,2,5), r_t('h2a,1,2,3),
                     r_t('h22,2,1,4), r_t('h25,3,4,5), r_t('h24,4,5,6), r_t('h20,5,6,30),
                     i_t('h3f,0,30,1), r_t('h21,5,6,30), HALT, i_t(8,0,30,77)};
        endcase
        for (int i = 0; i < 4096; i++) imem[i] = 32'd0;
        foreach (pr[i]) imem[i] = pr[i];
        if (p == 1) sb_q.push_back('{12'd0, 32'd7});
    endtask

    // one clock, then store scoreboard on dut1
    task automatic step();
        @(posedge clk); #1;
        if (we1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: addr %0d data %0d, required no store", da1, wd1);
            end else begin
                sb_e = sb_q.pop_front();
                if (da1 !== sb_e.addr || wd1 !== sb_e.data) begin
                    errors++;
                    $display("FAIL store: addr %0d data %0d, required addr %0d data %0d",
                             da1, wd1, sb_e.addr, sb_e.data);
                end
            end
        end
    endtask

    task automatic run_to_halt();
        for (int n = 0; n < 400 && !t_halt; n++) step();
        chk("halt_reached", 32'(t_halt), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] c, s;
        logic [11:0] a;
        logic        we_seen;
        rst_n = 1'b0;
        sel = v.fwd;
        sb_q.delete();
        load_prog(v.prog);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_to_halt();
        chk($sformatf("v%0d_rout", idx), t_rout, v.rout);
        chk($sformatf("v%0d_stalls", idx), t_stl, v.stalls);
        chk($sformatf("v%0d_sb_left", idx), 32'(sb_q.size()), 32'd0);
        c = t_cyc; s = t_stl; a = t_ia; we_seen = 1'b0;
        repeat (20) begin
            step();
            if (t_we) we_seen = 1'b1;
        end
        chk($sformatf("v%0d_frz_cycles", idx), t_cyc, c);
        chk($sformatf("v%0d_frz_stalls", idx), t_stl, s);
        chk($sformatf("v%0d_frz_iaddr", idx), 32'(t_ia), 32'(a));
        chk($sformatf("v%0d_frz_we", idx), 32'(we_seen), 32'd0);
        chk($sformatf("v%0d_frz_rout", idx), t_rout, v.rout);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b1;
        vecs[0] = '{0, 1'b1, 32'd13, 32'd0};
        vecs[1] = '{0, 1'b0, 32'd13, 32'd4};
        vecs[2] = '{1, 1'b1, 32'd14, 32'd1};
        vecs[3] = '{1, 1'b0, 32'd14, 32'd4};
        vecs[4] = '{2, 1'b1, 32'd18, 32'd1};
        vecs[5] = '{2, 1'b0, 32'd18, 32'd4};
        vecs[6] = '{3, 1'b1, 32'd17, 32'd0};
        vecs[7] = '{3, 1'b0, 32'd17, 32'd8};

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset asserted mid-program
        sel = 1'b1;
        sb_q.delete();
        rst_n = 1'b0;
        load_prog(3);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) step();
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rst_async_iaddr", 32'(ia1), 32'd0);
        chk("rst_async_we", 32'(we1), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_iaddr", k), 32'(ia1), 32'd0);
            chk($sformatf("rst%0d_we", k), 32'(we1), 32'd0);
            chk($sformatf("rst%0d_halt", k), 32'(halt1), 32'd0);
            chk($sformatf("rst%0d_rout", k), rout1, 32'd0);
            chk($sformatf("rst%0d_cycles", k), cyc1, 32'd0);
            chk($sformatf("rst%0d_stalls", k), stl1, 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rel_iaddr0", 32'(ia1), 32'd0);
        step();
        chk("rel_iaddr1", 32'(ia1), 32'd1);
        chk("rel_cycles1", cyc1, 32'd1);
        run_to_halt();
        chk("rel_rout", rout1, 32'd17);
        chk("rel_stalls", stl1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_proc12.md
# m_proc12

Five-stage pipelined MIPS-subset processor (IF/ID/EX/MEM/WB), successor to the current nop-scheduled pipeline. Adds operand forwarding, load-use and branch interlocks, an extended ALU, a compile-time forwarding mode and performance counters. Instruction and data memories sit outside the block as synchronous single-port RAMs with 1-cycle read latency, the same as the existing memory module. The block is the top-level compute core under the board wrapper and the simulation top.

## Interface
- IMEM_AW, 12, instruction memory word-address width.
- DMEM_AW, 12, data memory word-address width.
- FWD_EN, 1, 1 = full forwarding; 0 = interlock-only, where dependent instructions wait in ID.
- ROUT_REG, 30, architectural register mirrored on r_rout.
- w_clk  in  1  clock; all state changes on its rising edge.
- w_rst  in  1  reset, asynchronous, active-low.
- w_imem_addr  out  IMEM_AW  instruction word address.
- w_imem_data  in  32  instruction, valid 1 cycle after the address.
- w_dmem_addr  out  DMEM_AW  data word address, taken from ALU result [DMEM_AW+1:2].
- w_dmem_we  out  1  store enable.
- w_dmem_wdata  out  32  store data.
- w_dmem_rdata  in  32  load data, valid 1 cycle after the address.
- r_rout  out  32  last value written to ROUT_REG.
- r_halt  out  1  sticky halt flag.
- r_cycles  out  32  cycles since reset, frozen at halt.
- r_stalls  out  32  stall cycles since reset, frozen at halt.

## Operation
- Supported instructions:
  - R-type (op 0): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2a SLT (signed).
  - ADDI 0x08, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, HALT 0x11.
  - Any other op or funct executes as a NOP: no register write, no store.
- Destination: rd for R-type, rt for ADDI/LW. A write to $0 is discarded. Reads of $0 return 0.
- Register file:
  - 32x32, written in WB.
  - Write-through: an ID read of the register being written in the same cycle returns the new value.
  - Not reset.
- All arithmetic is 32-bit wraparound. Immediates are sign-extended.
- Branches:
  - Resolved in ID. Target = pc+4 + (simm<<2).
  - One architectural delay slot: the instruction already fetched always executes.
- Forwarding when FWD_EN=1:
  - EX operands: priority ExMe ALU result (non-load, writing, rd match), then the WB result (ALU or load data), then the IdEx value.
  - ID branch operands: ExMe ALU result, then the WB result.
- Stall conditions when FWD_EN=1 (ID instruction held, bubble into EX):
  - (a) ID source matches an IdEx load destination (load-use, 1 cycle).
  - (b) Branch source matches any writing IdEx destination.
  - (c) Branch source matches an ExMe load destination.
  - Net effect: a branch after an ALU producer stalls 1 cycle; after a load, 2 cycles.
- Stall conditions when FWD_EN=0:
  - Any ID source matches a writing destination in IdEx or ExMe.
  - The instruction proceeds once the producer is in WB, via write-through.
- Only true sources are checked:
  - rs and rt for R-type, SW, BEQ/BNE.
  - rs only for ADDI and LW.
  - Register $0 never causes a stall.
- During a stall:
  - r_pc and IfId are held.
  - w_imem_addr presents IfId_pc so the held instruction is re-read.
  - Bubble = NOP with all write and store enables 0.
- Halt:
  - HALT reaching WB sets r_halt.
  - From the next edge: PC, all pipeline registers and counters freeze, and w_dmem_we is 0.
  - Instructions younger than the HALT never write.
- r_rout updates in the same edge as the regfile write to ROUT_REG.

## Timing
- Reset (w_rst=0, asynchronous) clears:
  - r_pc and every pipeline register to NOP/0.
  - r_rout, r_halt, r_cycles, r_stalls to 0.
  - Outputs: w_imem_addr=0, w_dmem_we=0.
- First edge after reset release fetches word 0.
- Throughput is 1 instruction per cycle absent stalls.
- An instruction at address a presented in cycle n writes the regfile at the end of cycle n+4, plus any stall cycles.
- A taken branch in ID in cycle t: w_imem_addr = target in cycle t+1.
- A store asserts w_dmem_we during its MEM cycle. A load's data is consumed in WB.
- r_stalls increments in every cycle the stall condition is true and r_halt=0.
- Reset asserted mid-run aborts all in-flight instructions; no store completes after reset asserts.

## Test plan
- Reset: hold w_rst=0 for 3 cycles mid-program.
  - Required: w_imem_addr=0, w_dmem_we=0, r_halt=0, r_rout=0, r_cycles=0, r_stalls=0.
  - Release: word 0 is fetched next.
- FWD_EN=1, program addi $1,$0,5; addi $2,$1,3; add $30,$1,$2; halt.
  - Required: r_rout=13, r_stalls=0.
- FWD_EN=0, same program.
  - Required: r_rout=13, r_stalls=4.
- FWD_EN=1, program addi $4,$0,7; sw $4,0($0); lw $3,0($0); add $30,$3,$3; halt.
  - Required: w_dmem_we pulses once with address 0 and data 7; r_rout=14; r_stalls=1.
- FWD_EN=1, program addi $8,$0,1; bne $8,$0,+2; addi $30,$0,9 (delay slot); addi $30,$0,99 (skipped); add $30,$30,$30; halt.
  - Required: r_rout=18, r_stalls=1.
- Halt freeze: after r_halt=1, run 20 more cycles.
  - Required: r_cycles, r_stalls and w_imem_addr are unchanged; w_dmem_we=0; the instruction after halt is not written.
